uart_rx_sampler: RTL and testbench

Receive-side bit sampler and deserializer of the UART. It consumes the synchronized RX line and the registered falling-edge pulse produced by the edge-detector stage. On each falling edge it qualifies the start bit, then majority-samples the data, parity and stop bits on an oversampling baud tick. Completed characters go to the RX FIFO/regmap as a one-cycle valid strobe with error flags.

---
 rtl/uart_rx_sampler_if.sv | 13 +
 rtl/uart_rx_sampler.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sampler_if.sv
// Received-character stream from the UART RX sampler to the RX FIFO/regmap.
// The sampler drives the master side; the consumer reads through the slave side.
interface uart_rx_sampler_if #(
  parameter int MAX_DATA_WIDTH = 8
);
  logic [MAX_DATA_WIDTH-1:0] o_data;
  logic                      o_valid;
  logic                      o_parity_err;
  logic                      o_frame_err;

  modport master (output o_data, output o_valid, output o_parity_err, output o_frame_err);
  modport slave  (input  o_data, input  o_valid, input  o_parity_err, input  o_frame_err);
endinterface

// File: rtl/uart_rx_sampler.sv
// UART receive bit sampler: qualifies the start bit, majority-votes three mid-bit
// samples per bit on the oversampling tick and emits each character with error flags.
module uart_rx_sampler #(
  parameter int OVERSAMPLE     = 16,
  parameter int MAX_DATA_WIDTH = 8
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_rxd,
  input  logic       i_fall_edge,
  input  logic       i_baud_tick,
  input  logic       i_en,
  input  logic [1:0] i_data_len,
  input  logic       i_parity_en,
  input  logic       i_parity_odd,
  input  logic       i_stop2,
  output logic       o_busy,
  uart_rx_sampler_if.master rx
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] TICK_S2   = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t                    state_reg;
  logic [CW-1:0]             tick_cnt_reg;
  logic [1:0]                sample_reg;
  logic [2:0]                bit_idx_reg;
  logic [MAX_DATA_WIDTH-1:0] shift_reg;
  logic [1:0]                len_reg;
  logic                      par_en_reg;
  logic                      par_odd_reg;
  logic                      stop2_reg;
  logic                      perr_reg;
  logic                      ferr_reg;
  logic                      busy_reg;
  logic                      valid_reg;
  logic [MAX_DATA_WIDTH-1:0] data_out_reg;
  logic                      perr_out_reg;
  logic                      ferr_out_reg;

  logic [1:0]                sample_hit;
  logic                      at_s2;
  logic                      at_wrap;
  logic                      maj;
  logic                      parity_exp;
  logic [MAX_DATA_WIDTH-1:0] aligned;

  // The first two votes are stored; the third is the live line at the S2 tick.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_sample
    localparam logic [CW-1:0] POINT = CW'(OVERSAMPLE / 2 - 1 + gi);
    assign sample_hit[gi] = i_baud_tick && (tick_cnt_reg == POINT);
  end

  assign at_s2      = i_baud_tick && (tick_cnt_reg == TICK_S2);
  assign at_wrap    = i_baud_tick && (tick_cnt_reg == TICK_LAST);
  assign maj        = (sample_reg[0] & sample_reg[1]) | (sample_reg[0] & i_rxd) |
                      (sample_reg[1] & i_rxd);
  // Unreceived positions of the shift register stay zero, so a full-width XOR is safe.
  assign parity_exp = (^shift_reg) ^ par_odd_reg;
  assign aligned    = shift_reg >> (2'd3 - len_reg);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      sample_reg   <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      len_reg      <= '0;
      par_en_reg   <= 1'b0;
      par_odd_reg  <= 1'b0;
      stop2_reg    <= 1'b0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      data_out_reg <= '0;
      perr_out_reg <= 1'b0;
      ferr_out_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (sample_hit[0]) sample_reg[0] <= i_rxd;
      if (sample_hit[1]) sample_reg[1] <= i_rxd;
      if (i_baud_tick && state_reg != IDLE)
        tick_cnt_reg <= at_wrap ? '0 : tick_cnt_reg + CW'(1);

      if (state_reg != IDLE && !i_en) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (i_fall_edge && i_en) begin
              state_reg    <= START;
              tick_cnt_reg <= '0;
              bit_idx_reg  <= '0;
              shift_reg    <= '0;
              perr_reg     <= 1'b0;
              ferr_reg     <= 1'b0;
              len_reg      <= i_data_len;
              par_en_reg   <= i_parity_en;
              par_odd_reg  <= i_parity_odd;
              stop2_reg    <= i_stop2;
              busy_reg     <= 1'b1;
            end
          end
          START: begin
            if (at_s2 && maj) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else if (at_wrap) begin
              state_reg <= DATA;
            end
          end
          DATA: begin
            if (at_s2) shift_reg <= {maj, shift_reg[MAX_DATA_WIDTH-1:1]};
            if (at_wrap) begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              if (bit_idx_reg == {1'b0, len_reg} + 3'd4)
                state_reg <= par_en_reg ? PARITY : STOP1;
            end
          end
          PARITY: begin
            if (at_s2) perr_reg <= (maj != parity_exp);
            if (at_wrap) state_reg <= STOP1;
          end
          STOP1: begin
            // Single stop bit finishes at mid-bit so a start edge in its tail is caught.
            if (at_s2) begin
              if (stop2_reg) begin
                ferr_reg <= ~maj;
              end else begin
                state_reg    <= IDLE;
                busy_reg     <= 1'b0;
                valid_reg    <= 1'b1;
                data_out_reg <= aligned;
                perr_out_reg <= perr_reg;
                ferr_out_reg <= ~maj;
              end
            end
            if (at_wrap) state_reg <= STOP2;
          end
          STOP2: begin
            if (at_s2) begin
              state_reg    <= IDLE;
              busy_reg     <= 1'b0;
              valid_reg    <= 1'b1;
              data_out_reg <= aligned;
              perr_out_reg <= perr_reg;
              ferr_out_reg <= ferr_reg | ~maj;
            end
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_busy          = busy_reg;
  assign rx.o_data       = data_out_reg;
  assign rx.o_valid      = valid_reg;
  assign rx.o_parity_err = perr_out_reg;
  assign rx.o_frame_err  = ferr_out_reg;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: serial frames driven on a 1-in-4 baud tick,
// received characters compared against hand-computed values.
`timescale 1ns/1ps
module tb_uart_rx_sampler;

  logic       clk;
  logic       nrst;
  logic       rxd;
  logic       fall_edge;
  logic       baud_tick;
  logic       en;
  logic [1:0] data_len;
  logic       par_en;
  logic       par_odd;
  logic       stop2;
  logic       busy;
  int         tick_div;

  int         checks;
  int         errors;
  int         valid_cnt;
  logic [7:0] data_log [64];
  logic       perr_log [64];
  logic       ferr_log [64];

  uart_rx_sampler_if #(.MAX_DATA_WIDTH(8)) rx_if ();

  uart_rx_sampler #(.OVERSAMPLE(16), .MAX_DATA_WIDTH(8)) dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_rxd        (rxd),
    .i_fall_edge  (fall_edge),
    .i_baud_tick  (baud_tick),
    .i_en         (en),
    .i_data_len   (data_len),
    .i_parity_en  (par_en),
    .i_parity_odd (par_odd),
    .i_stop2      (stop2),
    .o_busy       (busy),
    .rx           (rx_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: one clock in every four, changed on the falling edge.
  initial begin
    baud_tick = 1'b0;
    tick_div  = 0;
    forever begin
      @(negedge clk);
      tick_div  = (tick_div + 1) % 4;
      baud_tick = (tick_div == 0);
    end
  end

  always @(negedge clk) begin
    if (rx_if.o_valid) begin
      if (valid_cnt < 64) begin
        data_log[valid_cnt] <= rx_if.o_data;
        perr_log[valid_cnt] <= rx_if.o_parity_err;
        ferr_log[valid_cnt] <= rx_if.o_frame_err;
      end
      valid_cnt <= valid_cnt + 1;
      $display("rx char: data=%02h perr=%0b ferr=%0b", rx_if.o_data,
               rx_if.o_parity_err, rx_if.o_frame_err);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_tick();
    @(posedge clk);
    while (!baud_tick) @(posedge clk);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    rxd = 1'b1;
    repeat (n) wait_tick();
  endtask

  // One bit period; optional low glitch on tick indices 5..7 (ticks 6..8 counted from 1).
  task automatic drive_bit(input logic v, input logic glitch);
    rxd = v;
    for (int i = 0; i < 16; i++) begin
      if (glitch && i == 5) rxd = 1'b0;
      if (glitch && i == 8) rxd = v;
      wait_tick();
    end
  endtask

  task automatic start_edge();
    rxd       = 1'b0;
    fall_edge = 1'b1;
    @(posedge clk);
    #1 fall_edge = 1'b0;
  endtask

  // par_mode: 0 none, 1 correct parity, 2 inverted parity. Caller is #1 after a tick.
  task automatic send_frame(input logic [7:0] d, input int nbits, input int par_mode,
                            input logic stop_val, input int glitch_bit);
    logic [7:0] mask;
    logic       p;
    start_edge();
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i], i == glitch_bit);
    if (par_mode != 0) begin
      mask = 8'hFF >> (8 - nbits);
      p = (^(d & mask)) ^ par_odd;
      if (par_mode == 2) p = ~p;
      drive_bit(p, 1'b0);
    end
    drive_bit(stop_val, 1'b0);
    if (stop2) drive_bit(stop_val, 1'b0);
  endtask

  task automatic test_reset();
    #22;
    checks++; if (rx_if.o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_if.o_data); end
    checks++; if (rx_if.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_if.o_valid); end
    checks++; if (rx_if.o_parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", rx_if.o_parity_err); end
    checks++; if (rx_if.o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", rx_if.o_frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    nrst = 1'b1;
    idle_ticks(4);
  endtask

  task automatic test_8n1_timing();
    logic [7:0] d;
    int         base;
    d = 8'h55; data_len = 2'd3; par_en = 1'b0; stop2 = 1'b0;
    base = valid_cnt;
    wait_tick();
    start_edge();
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 1'b0);
    rxd = 1'b1;
    repeat (9) wait_tick();
    checks++; if (rx_if.o_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_early: got %b expected 0 after tick 153", rx_if.o_valid); end
    wait_tick();
    checks++; if (rx_if.o_valid !== 1'b1) begin errors++; $display("FAIL t1_valid_at_154: got %b expected 1", rx_if.o_valid); end
    checks++; if (rx_if.o_data !== 8'h55) begin errors++; $display("FAIL t1_data: got %h expected 55", rx_if.o_data); end
    checks++; if (rx_if.o_parity_err !== 1'b0) begin errors++; $display("FAIL t1_perr: got %b expected 0", rx_if.o_parity_err); end
    checks++; if (rx_if.o_frame_err !== 1'b0) begin errors++; $display("FAIL t1_ferr: got %b expected 0", rx_if.o_frame_err); end
    @(posedge clk); #1;
    checks++; if (rx_if.o_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_width: got %b expected 0", rx_if.o_valid); end
    repeat (6) wait_tick();
    idle_ticks(4);
    checks++; if (valid_cnt - base !== 1) begin errors++; $display("FAIL t1_valid_count: got %0d expected 1", valid_cnt - base); end
  endtask

  task automatic test_parity();
    int base;
    data_len = 2'd2; par_en = 1'b1; par_odd = 1'b0; stop2 = 1'b0;
    base = valid_cnt;
    wait_tick();
    send_frame(8'h2A, 7, 2, 1'b1, -1);
    send_frame(8'h2A, 7, 1, 1'b1, -1);
    idle_ticks(4);
    checks++; if (valid_cnt - base !== 2) begin errors++; $display("FAIL par_count: got %0d expected 2", valid_cnt - base); end
    checks++; if (data_log[base] !== 8'h2A) begin errors++; $display("FAIL par_bad_data: got %h expected 2a", data_log[base]); end
    checks++; if (perr_log[base] !== 1'b1) begin errors++; $display("FAIL par_bad_perr: got %b expected 1", perr_log[base]); end
    checks++; if (ferr_log[base] !== 1'b0) begin errors++; $display("FAIL par_bad_ferr: got %b expected 0", ferr_log[base]); end
    checks++; if (data_log[base+1] !== 8'h2A) begin errors++; $display("FAIL par_good_data: got %h expected 2a", data_log[base+1]); end
    checks++; if (perr_log[base+1] !== 1'b0) begin errors++; $display("FAIL par_good_perr: got %b expected 0", perr_log[base+1]); end
  endtask

  task automatic test_frame_glitch();
    int base;
    data_len = 2'd3; par_en = 1'b0; stop2 = 1'b0;
    base = valid_cnt;
    wait_tick();
    send_frame(8'h00, 8, 0, 1'b0, -1);
    idle_ticks(4);
    send_frame(8'h81, 8, 0, 1'b1, 0);
    idle_ticks(4);
    checks++; if (valid_cnt - base !== 2) begin errors++; $display("FAIL ferr_count: got %0d expected 2", valid_cnt - base); end
    checks++; if (data_log[base] !== 8'h00) begin errors++; $display("FAIL break_data: got %h expected 00", data_log[base]); end
    checks++; if (ferr_log[base] !== 1'b1) begin errors++; $display("FAIL break_ferr: got %b expected 1", ferr_log[base]); end
    checks++; if (data_log[base+1] !== 8'h81) begin errors++; $display("FAIL glitch_data: got %h expected 81", data_log[base+1]); end
    checks++; if (ferr_log[base+1] !== 1'b0) begin errors++; $display("FAIL glitch_ferr: got %b expected 0", ferr_log[base+1]); end
  endtask

  task automatic test_false_start();
    int base;
    data_len = 2'd3; par_en = 1'b0; stop2 = 1'b0;
    base = valid_cnt;
    wait_tick();
    start_edge();
    repeat (4) wait_tick();
    rxd = 1'b1;
    repeat (4) wait_tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fs_busy_mid: got %b expected 1", busy); end
    repeat (2) wait_tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fs_busy_drop: got %b expected 0 after S2 tick", busy); end
    idle_ticks(8);
    checks++; if (valid_cnt !== base) begin errors++; $display("FAIL fs_no_valid: got %0d expected %0d", valid_cnt, base); end
    send_frame(8'hA5, 8, 0, 1'b1, -1);
    idle_ticks(4);
    checks++; if (data_log[base] !== 8'hA5 || valid_cnt - base !== 1) begin errors++; $display("FAIL fs_next_frame: got %h x%0d expected a5 x1", data_log[base], valid_cnt - base); end
  endtask

  task automatic test_back_to_back();
    int base;
    data_len = 2'd3; par_en = 1'b0; stop2 = 1'b1;
    base = valid_cnt;
    wait_tick();
    send_frame(8'h01, 8, 0, 1'b1, -1);
    send_frame(8'hFE, 8, 0, 1'b1, -1);
    idle_ticks(4);
    checks++; if (valid_cnt - base !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", valid_cnt - base); end
    checks++; if (data_log[base] !== 8'h01) begin errors++; $display("FAIL b2b_first: got %h expected 01", data_log[base]); end
    checks++; if (data_log[base+1] !== 8'hFE) begin errors++; $display("FAIL b2b_second: got %h expected fe", data_log[base+1]); end
    checks++; if (ferr_log[base+1] !== 1'b0) begin errors++; $display("FAIL b2b_ferr: got %b expected 0", ferr_log[base+1]); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    data_len = 2'd3; par_en = 1'b0; stop2 = 1'b0;
    wait_tick();
    start_edge();
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    repeat (5) wait_tick();
    #2 nrst = 1'b0;
    #1;
    checks++; if (rx_if.o_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", rx_if.o_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (rx_if.o_valid !== 1'b0 || rx_if.o_frame_err !== 1'b0 || rx_if.o_parity_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags: got v=%b p=%b f=%b expected 000", rx_if.o_valid, rx_if.o_parity_err, rx_if.o_frame_err); end
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    base = valid_cnt;
    idle_ticks(4);
    send_frame(8'h3C, 8, 0, 1'b1, -1);
    idle_ticks(4);
    checks++; if (data_log[base] !== 8'h3C || valid_cnt - base !== 1) begin errors++; $display("FAIL rst_next_frame: got %h x%0d expected 3c x1", data_log[base], valid_cnt - base); end
  endtask

  task automatic test_enable_drop();
    int         base;
    logic [7:0] d;
    d = 8'hF0; data_len = 2'd3; par_en = 1'b0; stop2 = 1'b0;
    base = valid_cnt;
    wait_tick();
    start_edge();
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
    rxd = d[4];
    repeat (5) wait_tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL en_busy_before: got %b expected 1", busy); end
    en = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_drop_idle: got %b expected 0", busy); end
    idle_ticks(4);
    start_edge();
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_edge_ignored: got %b expected 0", busy); end
    idle_ticks(4);
    en = 1'b1;
    idle_ticks(40);
    checks++; if (valid_cnt !== base) begin errors++; $display("FAIL en_no_valid: got %0d expected %0d", valid_cnt, base); end
  endtask

  initial begin
    checks = 0; errors = 0; valid_cnt = 0;
    nrst = 1'b0; rxd = 1'b1; fall_edge = 1'b0; en = 1'b1;
    data_len = 2'd3; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
    test_reset();
    test_8n1_timing();
    test_parity();
    test_frame_glitch();
    test_false_start();
    test_back_to_back();
    test_reset_mid_frame();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
